// File: rtl/norm_count.sv
// Iterative 16-bit normalizer: binary-search count of leading zeros (unsigned)
// or redundant sign bits (signed) over four fixed steps of 8, 4, 2, 1.
module norm_count (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_mode,
    input  logic [15:0] in,
    output logic        busy,
    output logic        done,
    output logic [15:0] out,
    output logic [3:0]  shift_amt,
    output logic        degenerate
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [1:0]  step;
    logic [15:0] work;
    logic [15:0] operand;
    logic [3:0]  count;
    logic        mode;

    logic [3:0]  amt;
    logic        hit;
    logic [15:0] work_next;
    logic [3:0]  count_next;

    // Signed mode needs one extra bit so the sign survives the shift.
    always_comb begin
        amt = 4'd8 >> step;
        hit = 1'b0;
        case (step)
            2'd0: hit = mode ? (work[15:7] == '0 || work[15:7] == '1) : (work[15:8] == '0);
            2'd1: hit = mode ? (work[15:11] == '0 || work[15:11] == '1) : (work[15:12] == '0);
            2'd2: hit = mode ? (work[15:13] == '0 || work[15:13] == '1) : (work[15:14] == '0);
            default: hit = mode ? (work[15] == work[14]) : !work[15];
        endcase
        work_next  = hit ? (work << amt) : work;
        count_next = hit ? (count + amt) : count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            step       <= 2'd0;
            work       <= '0;
            operand    <= '0;
            count      <= '0;
            mode       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            out        <= '0;
            shift_amt  <= '0;
            degenerate <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work    <= in;
                        operand <= in;
                        mode    <= signed_mode;
                        count   <= '0;
                        step    <= 2'd0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    work  <= work_next;
                    count <= count_next;
                    step  <= step + 2'd1;
                    if (step == 2'd3) begin
                        out        <= work_next;
                        shift_amt  <= count_next;
                        degenerate <= (operand == 16'h0000) || (mode && operand == 16'hFFFF);
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_norm_count.sv
// Bench for norm_count: directed corner cases with literal expectations, then a
// randomized sweep checked against a count-the-leading-bits reference model.
module tb_norm_count;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_mode;
    logic [15:0] in_v;
    logic        busy;
    logic        done;
    logic [15:0] out;
    logic [3:0]  shift_amt;
    logic        degenerate;

    int checks = 0;
    int errors = 0;

    logic [15:0] prev_out;
    logic [3:0]  prev_sh;
    logic        prev_deg;

    norm_count dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_mode(signed_mode),
        .in         (in_v),
        .busy       (busy),
        .done       (done),
        .out        (out),
        .shift_amt  (shift_amt),
        .degenerate (degenerate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Normalize by counting leading bits directly, without any binary search.
    function automatic void refModel(input logic [15:0] v, input logic m,
                                     output logic [3:0] sh, output logic [15:0] o,
                                     output logic d);
        int n = 0;
        if (!m) begin
            while (n < 16 && v[15-n] == 1'b0) n++;
            if (n > 15) n = 15;
        end else begin
            while (n < 15 && v[14-n] == v[15]) n++;
        end
        sh = n[3:0];
        o  = v << n;
        d  = m ? (v == 16'h0000 || v == 16'hFFFF) : (v == 16'h0000);
    endfunction

    // Starts an operation, checks busy/done timing and output hold, leaves the
    // bench in the done cycle so the next call starts back-to-back.
    task automatic applyStimulus(input logic [15:0] v, input logic m, input logic inject);
        start       = 1'b1;
        in_v        = v;
        signed_mode = m;
        step_clk();
        start = 1'b0;
        in_v  = 16'($urandom);
        for (int i = 1; i <= 4; i++) begin
            if (inject && i == 1) begin
                start       = 1'b1;
                in_v        = 16'h0001;
                signed_mode = ~m;
            end
            checkOutput("busy_run", busy, 1);
            checkOutput("done_early", done, 0);
            checkOutput("out_hold", out, prev_out);
            checkOutput("sh_hold", shift_amt, prev_sh);
            step_clk();
            start = 1'b0;
        end
        checkOutput("done_pulse", done, 1);
        checkOutput("busy_clear", busy, 0);
    endtask

    task automatic runDirected(input logic [15:0] v, input logic m, input logic inject,
                               input logic [3:0] esh, input logic [15:0] eout, input logic edeg);
        applyStimulus(v, m, inject);
        checkOutput($sformatf("sh_%h_%0d", v, m), shift_amt, esh);
        checkOutput($sformatf("out_%h_%0d", v, m), out, eout);
        checkOutput($sformatf("deg_%h_%0d", v, m), degenerate, edeg);
        prev_out = eout;
        prev_sh  = esh;
        prev_deg = edeg;
    endtask

    initial begin
        logic [3:0]  msh;
        logic [15:0] mout;
        logic        mdeg;
        logic [15:0] rv;
        logic        rm;

        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; in_v = '0;
        prev_out = '0; prev_sh = '0; prev_deg = 1'b0;
        step_clk();
        step_clk();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_out", out, 0);
        checkOutput("rst_sh", shift_amt, 0);
        checkOutput("rst_deg", degenerate, 0);
        rst = 1'b0;
        step_clk();

        runDirected(16'h0300, 1'b0, 1'b1, 4'd6,  16'hC000, 1'b0);
        runDirected(16'h0001, 1'b0, 1'b0, 4'd15, 16'h8000, 1'b0);
        runDirected(16'h0000, 1'b0, 1'b0, 4'd15, 16'h0000, 1'b1);
        runDirected(16'hFF80, 1'b1, 1'b0, 4'd8,  16'h8000, 1'b0);
        runDirected(16'h0001, 1'b1, 1'b0, 4'd14, 16'h4000, 1'b0);
        runDirected(16'hFFFF, 1'b1, 1'b0, 4'd15, 16'h8000, 1'b1);
        runDirected(16'h4000, 1'b1, 1'b0, 4'd0,  16'h4000, 1'b0);
        runDirected(16'h8000, 1'b0, 1'b0, 4'd0,  16'h8000, 1'b0);
        runDirected(16'h0000, 1'b1, 1'b0, 4'd15, 16'h0000, 1'b1);
        step_clk();
        checkOutput("done_one_cycle", done, 0);
        checkOutput("deg_hold_idle", degenerate, prev_deg);

        start = 1'b1; in_v = 16'h0300; signed_mode = 1'b0;
        step_clk();
        start = 1'b0;
        step_clk();
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_out", out, 0);
        checkOutput("abort_sh", shift_amt, 0);
        checkOutput("abort_deg", degenerate, 0);
        for (int i = 0; i < 6; i++) begin
            step_clk();
            checkOutput("abort_no_done", done, 0);
        end
        prev_out = '0; prev_sh = '0; prev_deg = 1'b0;

        for (int k = 0; k < 10000; k++) begin
            rv = 16'($urandom);
            case ($urandom_range(0, 7))
                0: rv = 16'h0000;
                1: rv = 16'hFFFF;
                2: rv = rv >> $urandom_range(0, 15);
                3: rv = 16'($signed(rv) >>> $urandom_range(0, 15));
                default: ;
            endcase
            rm = 1'($urandom);
            refModel(rv, rm, msh, mout, mdeg);
            applyStimulus(rv, rm, 1'b0);
            checkOutput("rnd_sh", shift_amt, msh);
            checkOutput("rnd_out", out, mout);
            checkOutput("rnd_deg", degenerate, mdeg);
            checkOutput("inv_shift", out, 16'(rv << shift_amt));
            if (!mdeg)
                checkOutput("inv_norm", rm ? (out[15] ^ out[14]) : out[15], 1);
            prev_out = mout;
            prev_sh  = msh;
            prev_deg = mdeg;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
